mem_access_seq: RTL and testbench

MEM_ACCESS_SEQ -- requirements
Module: mem_access_seq

---
 rtl/mem_access_seq_pkg.sv | 25 ++
 rtl/mem_access_seq_if.sv | 27 ++
 rtl/mem_access_seq.sv | 148 ++++++++++++++
 tb/tb_mem_access_seq.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_seq_pkg.sv
// Shared types for the memory access sequencer: FSM states, the captured
// request record and the wait-state ceiling.
package mem_pkg;

    localparam int MEM_WAIT_MAX = 15;

    typedef enum logic [2:0] {
        IDLE,
        MAR_LO,
        XFER_LO,
        MAR_HI,
        XFER_HI,
        RESP
    } mem_state_t;

    typedef struct packed {
        logic        write;
        logic        word;
        logic        zp;
        logic        part;
        logic [15:0] addr;
        logic [15:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/mem_access_seq_if.sv
// Request/response handshake between a requester (master) and the memory
// access sequencer (slave).
interface mem_access_seq_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic        req_word;
    logic        req_zp;
    logic        req_part;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_rdata;

    modport master (
        output req_valid, req_write, req_word, req_zp, req_part, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_write, req_word, req_zp, req_part, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata
    );

endinterface

// File: rtl/mem_access_seq.sv
// Memory access sequencer: turns byte/word read and write requests into MAR/MBR
// strobe sequences on a byte-wide memory bus, with optional wait states per byte.
module mem_access_seq
    import mem_pkg::*;
#(
    parameter int WAIT_CYCLES = 0
) (
    input  logic            clk,
    input  logic            rst,
    mem_access_seq_if.slave host,
    output logic            zero_page,
    output logic            mem_part,
    output logic            mem_out,
    output logic            mem_in,
    output logic            reg_mbr_load,
    output logic            reg_mbr_word_dir,
    output logic            reg_mar_load,
    output logic [15:0]     address,
    output logic [7:0]      data_drv,
    output logic            data_drv_en,
    input  logic [7:0]      data_bus
);

    localparam logic [3:0] WAIT_LIM = (WAIT_CYCLES > MEM_WAIT_MAX) ? 4'(MEM_WAIT_MAX)
                                                                   : 4'(WAIT_CYCLES);

    mem_state_t  state;
    mem_req_t    cap;
    logic [3:0]  wait_cnt;

    // Zero-page words wrap inside their page instead of carrying into the high byte.
    function automatic logic [15:0] next_byte_addr(input logic [15:0] a, input logic zp);
        if (zp) begin
            return {a[15:8], a[7:0] + 8'd1};
        end
        return a + 16'd1;
    endfunction

    // Outputs are decoded from the state being entered so every strobe is a flop
    // that lines up exactly with its state; strobes default to inactive each cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            cap              <= '0;
            wait_cnt         <= '0;
            host.req_ready   <= 1'b0;
            host.rsp_valid   <= 1'b0;
            host.rsp_rdata   <= '0;
            zero_page        <= 1'b1;
            mem_part         <= 1'b0;
            mem_out          <= 1'b1;
            mem_in           <= 1'b1;
            reg_mbr_load     <= 1'b0;
            reg_mbr_word_dir <= 1'b0;
            reg_mar_load     <= 1'b0;
            address          <= '0;
            data_drv         <= '0;
            data_drv_en      <= 1'b0;
        end else begin
            reg_mar_load     <= 1'b0;
            mem_out          <= 1'b1;
            mem_in           <= 1'b1;
            reg_mbr_load     <= 1'b0;
            reg_mbr_word_dir <= 1'b0;
            data_drv         <= '0;
            data_drv_en      <= 1'b0;

            unique case (state)
                IDLE: begin
                    host.req_ready <= 1'b1;
                    if (host.req_valid && host.req_ready) begin
                        cap.write      <= host.req_write;
                        cap.word       <= host.req_word;
                        cap.zp         <= host.req_zp;
                        cap.part       <= host.req_part;
                        cap.addr       <= host.req_addr;
                        cap.wdata      <= host.req_wdata;
                        host.req_ready <= 1'b0;
                        host.rsp_rdata <= '0;
                        address        <= host.req_addr;
                        reg_mar_load   <= 1'b1;
                        zero_page      <= ~host.req_zp;
                        mem_part       <= host.req_part;
                        state          <= MAR_LO;
                    end
                end

                MAR_LO, MAR_HI: begin
                    wait_cnt         <= '0;
                    zero_page        <= ~cap.zp;
                    mem_part         <= cap.part;
                    mem_out          <= cap.write;
                    mem_in           <= ~cap.write;
                    reg_mbr_load     <= ~cap.write;
                    data_drv_en      <= cap.write;
                    reg_mbr_word_dir <= (state == MAR_HI);
                    if (cap.write) begin
                        data_drv <= (state == MAR_HI) ? cap.wdata[15:8] : cap.wdata[7:0];
                    end
                    state <= (state == MAR_LO) ? XFER_LO : XFER_HI;
                end

                XFER_LO, XFER_HI: begin
                    if (wait_cnt != WAIT_LIM) begin
                        wait_cnt         <= wait_cnt + 4'd1;
                        mem_out          <= mem_out;
                        mem_in           <= mem_in;
                        reg_mbr_load     <= reg_mbr_load;
                        reg_mbr_word_dir <= reg_mbr_word_dir;
                        data_drv         <= data_drv;
                        data_drv_en      <= data_drv_en;
                    end else begin
                        if (!cap.write) begin
                            if (state == XFER_LO) begin
                                host.rsp_rdata[7:0] <= data_bus;
                            end else begin
                                host.rsp_rdata[15:8] <= data_bus;
                            end
                        end
                        if (state == XFER_LO && cap.word) begin
                            address      <= next_byte_addr(cap.addr, cap.zp);
                            reg_mar_load <= 1'b1;
                            state        <= MAR_HI;
                        end else begin
                            zero_page      <= 1'b1;
                            mem_part       <= 1'b0;
                            host.rsp_valid <= 1'b1;
                            state          <= RESP;
                        end
                    end
                end

                RESP: begin
                    if (host.rsp_ready) begin
                        host.rsp_valid <= 1'b0;
                        host.req_ready <= 1'b1;
                        state          <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_seq.sv
// Scoreboard bench for mem_access_seq: runs a zero-wait and a three-wait instance
// side by side on the same requests and checks timing, strobes and read data.
module tb_mem_access_seq;

    localparam int W0 = 0;
    localparam int W3 = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_access_seq_if if0 ();
    mem_access_seq_if if3 ();

    logic        zero_page0, mem_part0, mem_out0, mem_in0, mbr_load0, mbr_dir0, mar_load0, drv_en0;
    logic [15:0] address0;
    logic [7:0]  drv0, data_bus0;
    logic        zero_page3, mem_part3, mem_out3, mem_in3, mbr_load3, mbr_dir3, mar_load3, drv_en3;
    logic [15:0] address3;
    logic [7:0]  drv3, data_bus3;

    logic [7:0]  bus_lo, bus_hi;

    logic [15:0] exp_q0[$];
    logic [15:0] exp_q3[$];

    int n_compared   = 0;
    int n_mismatched = 0;

    // Memory model: returns the requested byte only while the MBR is loading.
    assign data_bus0 = !mbr_load0 ? 8'h5A : (mbr_dir0 ? bus_hi : bus_lo);
    assign data_bus3 = !mbr_load3 ? 8'h5A : (mbr_dir3 ? bus_hi : bus_lo);

    mem_access_seq #(.WAIT_CYCLES(W0)) dut0 (
        .clk(clk), .rst(rst), .host(if0),
        .zero_page(zero_page0), .mem_part(mem_part0), .mem_out(mem_out0), .mem_in(mem_in0),
        .reg_mbr_load(mbr_load0), .reg_mbr_word_dir(mbr_dir0), .reg_mar_load(mar_load0),
        .address(address0), .data_drv(drv0), .data_drv_en(drv_en0), .data_bus(data_bus0)
    );

    mem_access_seq #(.WAIT_CYCLES(W3)) dut3 (
        .clk(clk), .rst(rst), .host(if3),
        .zero_page(zero_page3), .mem_part(mem_part3), .mem_out(mem_out3), .mem_in(mem_in3),
        .reg_mbr_load(mbr_load3), .reg_mbr_word_dir(mbr_dir3), .reg_mar_load(mar_load3),
        .address(address3), .data_drv(drv3), .data_drv_en(drv_en3), .data_bus(data_bus3)
    );

    task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic set_fields(input logic wr, input logic wd, input logic zp, input logic part,
                              input logic [15:0] addr, input logic [15:0] wdata);
        if0.req_write = wr;  if3.req_write = wr;
        if0.req_word  = wd;  if3.req_word  = wd;
        if0.req_zp    = zp;  if3.req_zp    = zp;
        if0.req_part  = part; if3.req_part = part;
        if0.req_addr  = addr; if3.req_addr = addr;
        if0.req_wdata = wdata; if3.req_wdata = wdata;
    endtask

    task automatic wait_both_idle();
        int wait_n = 0;
        while (!(if0.req_ready && if3.req_ready) && wait_n < 40) begin
            @(negedge clk);
            wait_n++;
        end
        check_output("idle_wait", 32'(wait_n < 40), 32'd1);
    endtask

    // One request to both instances; hold > 0 keeps rsp_ready low on dut0 for that many cycles.
    task automatic apply_stimulus(input logic wr, input logic wd, input logic zp, input logic part,
                                  input logic [15:0] addr, input logic [15:0] wdata,
                                  input logic [7:0] lo, input logic [7:0] hi,
                                  input int hold, input logic [15:0] exp_hi_addr);
        int          cycle = 0, lat0 = 0, lat3 = 0, hs0 = 0, hs3 = 0;
        int          mar_cnt0 = 0, strobe0 = 0, strobe3 = 0, zp_cnt0 = 0, overlap = 0;
        int          drv_en_bad = 0, unstable = 0, rdy_bad = 0;
        logic        done0 = 1'b0, done3 = 1'b0, seen0 = 1'b0, seen3 = 1'b0;
        logic [15:0] mar_a0[2];
        logic [7:0]  drv_lo0 = 8'h00, drv_hi0 = 8'h00;
        logic [15:0] held_rdata = 16'h0000;
        logic [15:0] exp_rd;

        mar_a0[0] = 16'h0;
        mar_a0[1] = 16'h0;
        exp_rd = wr ? 16'h0000 : (wd ? {hi, lo} : {8'h00, lo});
        exp_q0.push_back(exp_rd);
        exp_q3.push_back(exp_rd);
        bus_lo = lo;
        bus_hi = hi;

        wait_both_idle();
        set_fields(wr, wd, zp, part, addr, wdata);
        if0.req_valid = 1'b1;
        if3.req_valid = 1'b1;
        @(negedge clk);
        cycle = 1;
        set_fields(~wr, ~wd, ~zp, ~part, ~addr, ~wdata);
        if0.req_valid = (hold > 0);
        if3.req_valid = 1'b0;

        while (cycle <= 60 && !(done0 && done3 && cycle > hs0 + 1 && cycle > hs3 + 1)) begin
            if (done0 && cycle == hs0 + 1) check_output("req_ready_rise0", 32'(if0.req_ready), 32'd1);
            if (done3 && cycle == hs3 + 1) check_output("req_ready_rise3", 32'(if3.req_ready), 32'd1);

            if (mar_load0) begin
                if (mar_cnt0 < 2) mar_a0[mar_cnt0] = address0;
                mar_cnt0++;
            end
            if (wr ? !mem_in0 : !mem_out0) strobe0++;
            if (wr ? !mem_in3 : !mem_out3) strobe3++;
            if (!mem_in0) begin
                if (mbr_dir0) drv_hi0 = drv0;
                else          drv_lo0 = drv0;
                if (!drv_en0) drv_en_bad++;
            end
            if (!zero_page0) zp_cnt0++;
            if ((!mem_in0 && !mem_out0) || (!mem_in3 && !mem_out3)) overlap++;

            if (!done0 && if0.rsp_valid) begin
                if (!seen0) begin
                    seen0 = 1'b1;
                    lat0 = cycle;
                    held_rdata = if0.rsp_rdata;
                end else if (if0.rsp_rdata !== held_rdata) begin
                    unstable++;
                end
                if (cycle - lat0 >= hold) begin
                    if0.rsp_ready = 1'b1;
                    if0.req_valid = 1'b0;
                    done0 = 1'b1;
                    hs0 = cycle;
                    check_output("sb_size0", 32'(exp_q0.size()), 32'd1);
                    if (exp_q0.size() > 0) check_output("rdata0", 32'(if0.rsp_rdata), 32'(exp_q0.pop_front()));
                end else begin
                    if0.rsp_ready = 1'b0;
                    if (if0.req_ready) rdy_bad++;
                end
            end

            if (!done3 && if3.rsp_valid) begin
                if (!seen3) begin
                    seen3 = 1'b1;
                    lat3 = cycle;
                end
                done3 = 1'b1;
                hs3 = cycle;
                check_output("sb_size3", 32'(exp_q3.size()), 32'd1);
                if (exp_q3.size() > 0) check_output("rdata3", 32'(if3.rsp_rdata), 32'(exp_q3.pop_front()));
            end

            @(negedge clk);
            cycle++;
        end

        if0.req_valid = 1'b0;
        if0.rsp_ready = 1'b1;
        check_output("rsp_done", {30'd0, done0, done3}, 32'd3);
        check_output("latency0", 32'(lat0), 32'(wd ? 5 + 2 * W0 : 3 + W0));
        check_output("latency3", 32'(lat3), 32'(wd ? 5 + 2 * W3 : 3 + W3));
        check_output("mar_pulses0", 32'(mar_cnt0), 32'(wd ? 2 : 1));
        check_output("mar_addr_lo0", 32'(mar_a0[0]), 32'(addr));
        if (wd) check_output("mar_addr_hi0", 32'(mar_a0[1]), 32'(exp_hi_addr));
        check_output("strobe_cycles0", 32'(strobe0), 32'((1 + W0) * (wd ? 2 : 1)));
        check_output("strobe_cycles3", 32'(strobe3), 32'((1 + W3) * (wd ? 2 : 1)));
        check_output("zero_page_cycles0", 32'(zp_cnt0), 32'(zp ? (wd ? 4 : 2) : 0));
        check_output("in_out_overlap", 32'(overlap), 32'd0);
        if (wr) begin
            check_output("data_drv_en0", 32'(drv_en_bad), 32'd0);
            check_output("data_drv_lo0", 32'(drv_lo0), 32'(wdata[7:0]));
            if (wd) check_output("data_drv_hi0", 32'(drv_hi0), 32'(wdata[15:8]));
        end
        if (hold > 0) begin
            check_output("bp_rdata_stable0", 32'(unstable), 32'd0);
            check_output("bp_req_ready_low0", 32'(rdy_bad), 32'd0);
        end
    endtask

    // Abort a word read while dut0 is in its high-byte transfer.
    task automatic reset_mid_xfer();
        int cycle = 0;
        int rsp_seen = 0;

        bus_lo = 8'h99;
        bus_hi = 8'h66;
        wait_both_idle();
        set_fields(1'b0, 1'b1, 1'b0, 1'b1, 16'h2000, 16'h0000);
        if0.req_valid = 1'b1;
        if3.req_valid = 1'b1;
        @(negedge clk);
        cycle = 1;
        if0.req_valid = 1'b0;
        if3.req_valid = 1'b0;
        while (!(mbr_load0 && mbr_dir0) && cycle < 20) begin
            @(negedge clk);
            cycle++;
        end
        check_output("reach_xfer_hi", 32'(mbr_load0 && mbr_dir0), 32'd1);
        check_output("xfer_hi_cycle", 32'(cycle), 32'd4);
        rst = 1'b1;
        @(negedge clk);
        check_output("abort_mem_out", 32'(mem_out0), 32'd1);
        check_output("abort_rsp_valid", 32'(if0.rsp_valid), 32'd0);
        check_output("abort_req_ready", 32'(if0.req_ready), 32'd0);
        check_output("abort_mbr_load", 32'(mbr_load0), 32'd0);
        check_output("abort_rdata", 32'(if0.rsp_rdata), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (if0.rsp_valid || if3.rsp_valid) rsp_seen++;
        end
        check_output("no_rsp_after_abort", 32'(rsp_seen), 32'd0);
        check_output("idle_after_abort", 32'(if0.req_ready && if3.req_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: time limit reached, compared %0d", n_compared);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int mar_seen = 0;

        rst = 1'b1;
        bus_lo = 8'h00;
        bus_hi = 8'h00;
        set_fields(1'b0, 1'b0, 1'b0, 1'b0, 16'h0042, 16'h0000);
        if0.req_valid = 1'b1;
        if3.req_valid = 1'b1;
        if0.rsp_ready = 1'b1;
        if3.rsp_ready = 1'b1;
        repeat (3) @(negedge clk);

        check_output("rst_req_ready", 32'(if0.req_ready), 32'd0);
        check_output("rst_rsp_valid", 32'(if0.rsp_valid), 32'd0);
        check_output("rst_rsp_rdata", 32'(if0.rsp_rdata), 32'd0);
        check_output("rst_zero_page", 32'(zero_page0), 32'd1);
        check_output("rst_mem_out_in", {30'd0, mem_out0, mem_in0}, 32'd3);
        check_output("rst_strobes", {26'd0, mem_part0, mbr_load0, mbr_dir0, mar_load0, drv_en0, mem_in3}, 32'd1);
        check_output("rst_address", 32'(address0), 32'd0);
        check_output("rst_data_drv", 32'(drv0), 32'd0);

        rst = 1'b0;
        if0.req_valid = 1'b0;
        if3.req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (mar_load0 || mar_load3) mar_seen++;
        end
        check_output("no_accept_in_reset", 32'(mar_seen), 32'd0);

        //              wr    wd    zp    part  addr      wdata     lo     hi     hold exp_hi
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'h1234, 16'h0000, 8'hA5, 8'h3C, 0, 16'h0000);
        apply_stimulus(1'b1, 1'b1, 1'b0, 1'b1, 16'hFFFF, 16'hBEEF, 8'h00, 8'h00, 0, 16'h0000);
        apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, 16'h00FF, 16'h0000, 8'h11, 8'h22, 0, 16'h0000);
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 16'h4321, 16'h77CC, 8'h00, 8'h00, 0, 16'h0000);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 16'h0810, 16'h0000, 8'h3C, 8'hC3, 4, 16'h0000);
        apply_stimulus(1'b1, 1'b1, 1'b1, 1'b0, 16'h12FF, 16'h1357, 8'h00, 8'h00, 0, 16'h1200);
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 16'h12FF, 16'h0000, 8'h4D, 8'hE7, 0, 16'h1300);
        reset_mid_xfer();
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'h0001, 16'h0000, 8'h80, 8'h01, 0, 16'h0000);

        check_output("sb_drain0", 32'(exp_q0.size()), 32'd0);
        check_output("sb_drain3", 32'(exp_q3.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
